// File: rtl/axis_segin_hdr_insert_pkg.sv
// Package axis_segin_pkg: shared configuration, types and helpers for the
// segmented-input header inserter.
//
// Contents:
//   - bus geometry (AXIS_BUS_WIDTH, AXIS_TUSER_WIDTH, NUM_SEGMENTS and the
//     derived segment width / bytes / header-count width / write-vector width)
//   - state_t       : FSM state enum (IDLE, HDR, BODY)
//   - out_beat_t    : one registered output beat
//   - seg_rotate()  : lane rotation of segment data by s (modulo N)
//   - keep_rotate() : identical rotation applied to per-segment keep
//
// NUM_SEGMENTS must be a power of two >= 2. Rotation indices are computed in
// HDR_CNT_BITS arithmetic, so the natural wrap of that width is the modulo.
package axis_segin_pkg;

  localparam int AXIS_BUS_WIDTH   = 64;
  localparam int AXIS_TUSER_WIDTH = 4;
  localparam int NUM_SEGMENTS     = 4;
  localparam int AXIS_SEG_WIDTH   = AXIS_BUS_WIDTH / NUM_SEGMENTS;
  localparam int NUM_SEG_BYTES    = AXIS_SEG_WIDTH / 8;
  localparam int AXIS_KEEP_WIDTH  = AXIS_BUS_WIDTH / 8;
  localparam int HDR_CNT_BITS     = $clog2(NUM_SEGMENTS);
  // Bits [N-1:0] write the current row, bits [2N-2:N] write the next row.
  localparam int WRITE_WIDTH      = 2 * NUM_SEGMENTS - 1;

  typedef logic [NUM_SEGMENTS-1:0][AXIS_SEG_WIDTH-1:0] seg_data_t;
  typedef logic [NUM_SEGMENTS-1:0][NUM_SEG_BYTES-1:0]  seg_keep_t;
  typedef logic [HDR_CNT_BITS-1:0]                     hdr_cnt_t;
  typedef logic [WRITE_WIDTH-1:0]                      write_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2
  } state_t;

  typedef struct packed {
    seg_data_t                   data;
    seg_keep_t                   keep;
    logic [AXIS_TUSER_WIDTH-1:0] user;
    logic                        last;
    write_t                      wr;
  } out_beat_t;

  // Output lane j carries input segment (j - s) mod N.
  function automatic seg_data_t seg_rotate(input seg_data_t data, input hdr_cnt_t s);
    seg_data_t r;
    hdr_cnt_t  src;
    r = '0;
    for (int j = 0; j < NUM_SEGMENTS; j++) begin
      src  = hdr_cnt_t'(j) - s;
      r[j] = data[src];
    end
    return r;
  endfunction

  function automatic seg_keep_t keep_rotate(input seg_keep_t keep, input hdr_cnt_t s);
    seg_keep_t r;
    hdr_cnt_t  src;
    r = '0;
    for (int j = 0; j < NUM_SEGMENTS; j++) begin
      src  = hdr_cnt_t'(j) - s;
      r[j] = keep[src];
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_segin_hdr_insert_if.sv
// Interface axis_segin_if: bundles the payload stream, the header side
// channel and the segmented output stream of axis_segin_hdr_insert.
//
// Handshake rule for all three channels: a transfer happens on a rising aclk
// edge where both valid and ready are high; once valid is raised the
// producer holds it and its data stable until that transfer.
//
// Modports:
//   slave  : the inserter's view (consumes axis_in_* / hdr_*, drives axis_out_*)
//   master : the environment's view (drives axis_in_* / hdr_*, consumes axis_out_*)
interface axis_segin_if
  import axis_segin_pkg::*;
();

  logic [AXIS_BUS_WIDTH-1:0]   axis_in_tdata;
  logic [AXIS_KEEP_WIDTH-1:0]  axis_in_tkeep;
  logic [AXIS_TUSER_WIDTH-1:0] axis_in_tuser;
  logic                        axis_in_tlast;
  logic                        axis_in_tvalid;
  logic                        axis_in_tready;

  logic [AXIS_BUS_WIDTH-1:0]   hdr_tdata;
  hdr_cnt_t                    hdr_nsegs;
  logic                        hdr_tvalid;
  logic                        hdr_tready;

  seg_data_t                   axis_out_tdata;
  seg_keep_t                   axis_out_tkeep;
  logic [AXIS_TUSER_WIDTH-1:0] axis_out_tuser;
  logic                        axis_out_tlast;
  logic                        axis_out_tvalid;
  logic                        axis_out_tready;
  write_t                      axis_out_write;

  modport slave (
    input  axis_in_tdata, axis_in_tkeep, axis_in_tuser, axis_in_tlast, axis_in_tvalid,
    output axis_in_tready,
    input  hdr_tdata, hdr_nsegs, hdr_tvalid,
    output hdr_tready,
    output axis_out_tdata, axis_out_tkeep, axis_out_tuser, axis_out_tlast,
    output axis_out_tvalid, axis_out_write,
    input  axis_out_tready
  );

  modport master (
    output axis_in_tdata, axis_in_tkeep, axis_in_tuser, axis_in_tlast, axis_in_tvalid,
    input  axis_in_tready,
    output hdr_tdata, hdr_nsegs, hdr_tvalid,
    input  hdr_tready,
    input  axis_out_tdata, axis_out_tkeep, axis_out_tuser, axis_out_tlast,
    input  axis_out_tvalid, axis_out_write,
    output axis_out_tready
  );

endinterface

// File: rtl/axis_segin_hdr_insert_reg_slice.sv
// axis_segin_reg_slice: single-entry output register with valid/ready.
//
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset
//   i_valid       : upstream beat valid
//   o_ready       : slice can accept a beat this cycle (empty or draining)
//   i_data        : upstream beat (W bits)
//   o_valid       : registered beat valid
//   i_ready       : downstream ready
//   o_data        : registered beat
module axis_segin_reg_slice #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/axis_segin_hdr_insert.sv
// axis_segin_hdr_insert: prepends a 0..N-1 segment header to each full-width
// AXI stream packet and emits rotated segment lanes plus the (2N-1)-bit
// segment write vector for the segmented shift FIFO. One beat of latency
// through a registered output slice.
//
// Ports:
//   aclk, aresetn : clock, synchronous active-low reset
//   bus           : axis_segin_if.slave (payload in, header in, segmented out)
//   o_dbg_state   : current FSM state
//   pkt_count     : (AXIS_SEGIN_HDR_STAT_EN only) output beats fired with tlast
//   hdr_seg_total : (AXIS_SEGIN_HDR_STAT_EN only) sum of header lengths taken
//
// Optional feature macro: AXIS_SEGIN_HDR_STAT_EN.
module axis_segin_hdr_insert
  import axis_segin_pkg::*;
(
  input  logic   aclk,
  input  logic   aresetn,
  axis_segin_if.slave bus,
  output state_t o_dbg_state
`ifdef AXIS_SEGIN_HDR_STAT_EN
  ,
  output logic [31:0] pkt_count,
  output logic [31:0] hdr_seg_total
`endif
);

  state_t    r_state;
  state_t    w_next;
  hdr_cnt_t  r_s;
  seg_data_t r_hdr;

  logic      w_latch;
  logic      w_hdr_tready;
  logic      w_in_tready;
  logic      w_beat_valid;
  logic      w_slice_ready;
  out_beat_t w_beat;
  out_beat_t w_out;
  logic      w_out_valid;
  seg_data_t w_rot_data;
  seg_keep_t w_rot_keep;

  assign w_rot_data = seg_rotate(bus.axis_in_tdata, r_s);
  assign w_rot_keep = keep_rotate(bus.axis_in_tkeep, r_s);

  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_hdr_tready = 1'b0;
    w_in_tready  = 1'b0;
    w_beat_valid = 1'b0;
    w_beat       = '0;
    w_beat.user  = bus.axis_in_tuser;
    unique case (r_state)
      IDLE: begin
        // Header and first payload beat must both be present so the header
        // beat can carry the payload's tuser.
        if (bus.hdr_tvalid && bus.axis_in_tvalid) begin
          w_hdr_tready = 1'b1;
          w_latch      = 1'b1;
          w_next       = (bus.hdr_nsegs == '0) ? BODY : HDR;
        end
      end
      HDR: begin
        w_beat_valid = 1'b1;
        for (int j = 0; j < NUM_SEGMENTS; j++) begin
          if (hdr_cnt_t'(j) < r_s) begin
            w_beat.data[j] = r_hdr[j];
            w_beat.keep[j] = '1;
            w_beat.wr[j]   = 1'b1;
          end
        end
        if (w_slice_ready) begin
          w_next = BODY;
        end
      end
      BODY: begin
        w_in_tready  = w_slice_ready;
        w_beat_valid = bus.axis_in_tvalid;
        w_beat.data  = w_rot_data;
        w_beat.keep  = w_rot_keep;
        w_beat.last  = bus.axis_in_tlast;
        // Lanes at or above s land in the current row.
        for (int j = 0; j < NUM_SEGMENTS; j++) begin
          if (hdr_cnt_t'(j) >= r_s) begin
            w_beat.wr[j] = |w_rot_keep[j];
          end
        end
        // Lanes below s wrapped around into the next row. Lane N-1 can never
        // wrap since s <= N-1.
        for (int j = 0; j < NUM_SEGMENTS - 1; j++) begin
          if (hdr_cnt_t'(j) < r_s) begin
            w_beat.wr[NUM_SEGMENTS + j] = |w_rot_keep[j];
          end
        end
        if (bus.axis_in_tvalid && w_slice_ready && bus.axis_in_tlast) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    // Keep every handshake quiet while reset is held.
    if (!aresetn) begin
      w_latch      = 1'b0;
      w_hdr_tready = 1'b0;
      w_in_tready  = 1'b0;
      w_beat_valid = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_hdr   <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_s   <= bus.hdr_nsegs;
        r_hdr <= bus.hdr_tdata;
      end
    end
  end

  axis_segin_reg_slice #(
    .W($bits(out_beat_t))
  ) u_slice (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_valid (w_beat_valid),
    .o_ready (w_slice_ready),
    .i_data  (w_beat),
    .o_valid (w_out_valid),
    .i_ready (bus.axis_out_tready),
    .o_data  (w_out)
  );

  assign bus.axis_in_tready  = w_in_tready;
  assign bus.hdr_tready      = w_hdr_tready;
  assign bus.axis_out_tdata  = w_out.data;
  assign bus.axis_out_tkeep  = w_out.keep;
  assign bus.axis_out_tuser  = w_out.user;
  assign bus.axis_out_tlast  = w_out.last;
  assign bus.axis_out_write  = w_out.wr;
  assign bus.axis_out_tvalid = w_out_valid;
  assign o_dbg_state         = r_state;

`ifdef AXIS_SEGIN_HDR_STAT_EN
  logic [31:0] r_pkt_count;
  logic [31:0] r_hdr_seg_total;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_pkt_count     <= '0;
      r_hdr_seg_total <= '0;
    end else begin
      if (w_out_valid && bus.axis_out_tready && w_out.last) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
      // A zero-length header adds nothing, so counting at the latch point
      // equals counting on entry to HDR.
      if (w_latch) begin
        r_hdr_seg_total <= r_hdr_seg_total + 32'(bus.hdr_nsegs);
      end
    end
  end

  assign pkt_count     = r_pkt_count;
  assign hdr_seg_total = r_hdr_seg_total;
`endif

endmodule

// File: tb/tb_axis_segin_hdr_insert.sv
// Directed testbench for axis_segin_hdr_insert (N=4, 16-bit segments).
module tb_axis_segin_hdr_insert;
  import axis_segin_pkg::*;

  localparam int DW    = AXIS_BUS_WIDTH;
  localparam int KW    = AXIS_KEEP_WIDTH;
  localparam int UW    = AXIS_TUSER_WIDTH;
  localparam int WW    = WRITE_WIDTH;
  localparam int L_OFF = WW;
  localparam int U_OFF = WW + 1;
  localparam int K_OFF = U_OFF + UW;
  localparam int D_OFF = K_OFF + KW;
  localparam int EW    = D_OFF + DW;
  localparam int IW    = DW + KW + UW + 1;
  localparam int HW    = DW + HDR_CNT_BITS;

  // clock / reset
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axis_segin_if bus();
  state_t dbg_state;
`ifdef AXIS_SEGIN_HDR_STAT_EN
  logic [31:0] pkt_count;
  logic [31:0] hdr_seg_total;
`endif

  axis_segin_hdr_insert dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bus         (bus),
    .o_dbg_state (dbg_state)
`ifdef AXIS_SEGIN_HDR_STAT_EN
    ,
    .pkt_count     (pkt_count),
    .hdr_seg_total (hdr_seg_total)
`endif
  );

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [IW-1:0] in_q[$];
  logic [HW-1:0] hdr_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int hdr_pulses = 0;
  string cur_test = "reset";

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s.%s: got %0h expected %0h", cur_test, tag, obs, exp);
  endtask

  // driver tasks
  task automatic push_hdr(input logic [DW-1:0] d, input int s);
    assert (s >= 0 && s < NUM_SEGMENTS)
      else $error("FAIL hdr_nsegs: got %0d expected < %0d", s, NUM_SEGMENTS);
    hdr_q.push_back({d, hdr_cnt_t'(s)});
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic [UW-1:0] u, input logic l);
    in_q.push_back({d, k, u, l});
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [KW-1:0] k,
                          input logic [UW-1:0] u, input logic l, input logic [WW-1:0] w);
    exp_q.push_back({d, k, u, l, w});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && in_q.size() == 0 && hdr_q.size() == 0) break;
      @(posedge aclk);
    end
    chk("drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic wait_state(input state_t st);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (dbg_state == st) break;
    end
    chk("state_reached", 64'(i < 200), 64'd1);
  endtask

  // header driver: holds the queue front until hdr_tready is seen
  initial begin
    logic fire;
    bus.hdr_tvalid = 1'b0;
    bus.hdr_tdata  = '0;
    bus.hdr_nsegs  = '0;
    forever begin
      @(negedge aclk);
      fire = bus.hdr_tvalid && bus.hdr_tready;
      @(posedge aclk);
      #1;
      if (fire && hdr_q.size() > 0) void'(hdr_q.pop_front());
      if (hdr_q.size() > 0) begin
        {bus.hdr_tdata, bus.hdr_nsegs} = hdr_q[0];
        bus.hdr_tvalid = 1'b1;
      end else begin
        bus.hdr_tvalid = 1'b0;
      end
    end
  end

  // payload driver
  initial begin
    logic fire;
    bus.axis_in_tvalid = 1'b0;
    bus.axis_in_tdata  = '0;
    bus.axis_in_tkeep  = '0;
    bus.axis_in_tuser  = '0;
    bus.axis_in_tlast  = 1'b0;
    forever begin
      @(negedge aclk);
      fire = bus.axis_in_tvalid && bus.axis_in_tready;
      @(posedge aclk);
      #1;
      if (fire && in_q.size() > 0) void'(in_q.pop_front());
      if (in_q.size() > 0) begin
        {bus.axis_in_tdata, bus.axis_in_tkeep, bus.axis_in_tuser, bus.axis_in_tlast} = in_q[0];
        bus.axis_in_tvalid = 1'b1;
      end else begin
        bus.axis_in_tvalid = 1'b0;
      end
    end
  end

  // output monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge aclk);
      if (bus.hdr_tvalid && bus.hdr_tready) hdr_pulses++;
      if (aresetn && bus.axis_out_tvalid && bus.axis_out_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 64'(bus.axis_out_tdata), 64'(e[D_OFF +: DW]));
          chk("tkeep", 64'(bus.axis_out_tkeep), 64'(e[K_OFF +: KW]));
          chk("tuser", 64'(bus.axis_out_tuser), 64'(e[U_OFF +: UW]));
          chk("tlast", 64'(bus.axis_out_tlast), 64'(e[L_OFF]));
          chk("write", 64'(bus.axis_out_write), 64'(e[WW-1:0]));
        end
      end
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] e;
    bus.axis_out_tready = 1'b1;
    aresetn = 1'b0;
    // Test 1 traffic is queued while reset is held; nothing may be consumed.
    push_hdr(64'h0, 0);
    push_beat(64'h4444_3333_2222_1111, 8'hFF, 4'h1, 1'b0);
    push_beat(64'h8888_7777_6666_5555, 8'hFF, 4'h2, 1'b1);
    push_exp(64'h4444_3333_2222_1111, 8'hFF, 4'h1, 1'b0, 7'h0F);
    push_exp(64'h8888_7777_6666_5555, 8'hFF, 4'h2, 1'b1, 7'h0F);
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    chk("out_tvalid", 64'(bus.axis_out_tvalid), 64'd0);
    chk("in_tready", 64'(bus.axis_in_tready), 64'd0);
    chk("hdr_tready", 64'(bus.hdr_tready), 64'd0);
    chk("out_write", 64'(bus.axis_out_write), 64'd0);
    chk("state", 64'(dbg_state), 64'(IDLE));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // 1: s=0, two full beats, lanes unrotated
    cur_test = "t1_s0";
    wait_drain();

    // 2: s=1, single payload beat
    cur_test = "t2_s1";
    push_hdr(64'h0000_0000_0000_AAAA, 1);
    push_beat(64'h0003_0002_0001_0000, 8'hFF, 4'h5, 1'b1);
    push_exp(64'h0000_0000_0000_AAAA, 8'h03, 4'h5, 1'b0, 7'h01);
    push_exp(64'h0002_0001_0000_0003, 8'hFF, 4'h5, 1'b1, 7'h1E);
    wait_drain();

    // 3: s=3, only segments 0 and 1 kept
    cur_test = "t3_s3";
    push_hdr(64'h0000_CCCC_BBBB_AAAA, 3);
    push_beat(64'h4444_3333_2222_1111, 8'h0F, 4'h9, 1'b1);
    push_exp(64'h0000_CCCC_BBBB_AAAA, 8'h3F, 4'h9, 1'b0, 7'h07);
    push_exp(64'h1111_4444_3333_2222, 8'hC3, 4'h9, 1'b1, 7'h18);
    wait_drain();

    // 4: downstream stall of 5 cycles in BODY
    cur_test = "t4_stall";
    push_hdr(64'h0000_0000_0000_5555, 1);
    push_beat(64'h0004_0003_0002_0001, 8'hFF, 4'h3, 1'b0);
    push_beat(64'h0008_0007_0006_0005, 8'hFF, 4'h4, 1'b0);
    push_beat(64'h000C_000B_000A_0009, 8'hFF, 4'h5, 1'b1);
    push_exp(64'h0000_0000_0000_5555, 8'h03, 4'h3, 1'b0, 7'h01);
    push_exp(64'h0003_0002_0001_0004, 8'hFF, 4'h3, 1'b0, 7'h1E);
    push_exp(64'h0007_0006_0005_0008, 8'hFF, 4'h4, 1'b0, 7'h1E);
    push_exp(64'h000B_000A_0009_000C, 8'hFF, 4'h5, 1'b1, 7'h1E);
    wait_state(BODY);
    @(posedge aclk);
    #1;
    bus.axis_out_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      e = (exp_q.size() > 0) ? exp_q[0] : '0;
      chk("stall_in_tready", 64'(bus.axis_in_tready), 64'd0);
      chk("stall_tvalid", 64'(bus.axis_out_tvalid), 64'd1);
      chk("stall_tdata", 64'(bus.axis_out_tdata), 64'(e[D_OFF +: DW]));
    end
    @(posedge aclk);
    #1;
    bus.axis_out_tready = 1'b1;
    wait_drain();

    // 5: back-to-back, s=2 then s=0, hdr_tvalid stays high between them
    cur_test = "t5_b2b";
    hdr_pulses = 0;
    push_hdr(64'h0000_0000_EEEE_DDDD, 2);
    push_hdr(64'h0, 0);
    push_beat(64'h0004_0003_0002_0001, 8'hFF, 4'h1, 1'b1);
    push_beat(64'h0000_0000_9999_8888, 8'h0F, 4'h2, 1'b1);
    push_exp(64'h0000_0000_EEEE_DDDD, 8'h0F, 4'h1, 1'b0, 7'h03);
    push_exp(64'h0002_0001_0004_0003, 8'hFF, 4'h1, 1'b1, 7'h3C);
    push_exp(64'h0000_0000_9999_8888, 8'h0F, 4'h2, 1'b1, 7'h03);
    wait_drain();
    chk("hdr_pulses", 64'(hdr_pulses), 64'd2);

    // 7: all-zero keep beat still carries tlast, no write bits
    cur_test = "t7_zero_keep";
    push_hdr(64'h0, 0);
    push_beat(64'h1234_5678_9ABC_DEF0, 8'h00, 4'h7, 1'b1);
    push_exp(64'h1234_5678_9ABC_DEF0, 8'h00, 4'h7, 1'b1, 7'h00);
    wait_drain();

    // 6: reset in the middle of a 4-beat packet
    cur_test = "t6_reset";
    bus.axis_out_tready = 1'b0;
    push_hdr(64'h0, 0);
    for (int i = 0; i < 4; i++) push_beat(64'(i + 1), 8'hFF, 4'h0, 1'b0 | (i == 3));
    wait_state(BODY);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    in_q.delete();
    hdr_q.delete();
    @(posedge aclk);
    @(negedge aclk);
    chk("out_tvalid", 64'(bus.axis_out_tvalid), 64'd0);
    chk("out_tdata", 64'(bus.axis_out_tdata), 64'd0);
    chk("out_tlast", 64'(bus.axis_out_tlast), 64'd0);
    chk("out_write", 64'(bus.axis_out_write), 64'd0);
    chk("in_tready", 64'(bus.axis_in_tready), 64'd0);
    chk("hdr_tready", 64'(bus.hdr_tready), 64'd0);
    chk("state", 64'(dbg_state), 64'(IDLE));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    bus.axis_out_tready = 1'b1;
    cur_test = "t6_after";
    push_hdr(64'h0000_0000_0000_7777, 1);
    push_beat(64'h0004_0003_0002_0001, 8'hFF, 4'h6, 1'b1);
    push_exp(64'h0000_0000_0000_7777, 8'h03, 4'h6, 1'b0, 7'h01);
    push_exp(64'h0003_0002_0001_0004, 8'hFF, 4'h6, 1'b1, 7'h1E);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
